vector_sequencer: RTL and testbench

VECTOR_SEQUENCER -- requirements
Module: vector_sequencer

---
 rtl/vector_sequencer.sv | 110 +++++++++++
 tb/tb_vector_sequencer.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/vector_sequencer.sv
// Vector sequencer: plays a programmed table of control vectors out one per
// cycle, either once, looped, or one vector per Step pulse.
module vector_sequencer #(
   parameter int VEC_W = 42,
   parameter int DEPTH = 16,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic             Clock,
   input  logic             Reset,
   input  logic             Load_en,
   input  logic [AW-1:0]    Load_addr,
   input  logic [VEC_W-1:0] Load_data,
   input  logic             Start,
   input  logic             Stop,
   input  logic             Step,
   input  logic [1:0]       Mode,
   input  logic [AW-1:0]    Last_idx,
   output logic [VEC_W-1:0] Vec_out,
   output logic             Vec_valid,
   output logic [AW-1:0]    Vec_idx,
   output logic             Busy,
   output logic             Done,
   output logic [15:0]      Applied_count
);

   typedef enum logic [1:0] {IDLE, RUN, STEP_WAIT, DONE} state_t;

   state_t           state_q, state_nxt;
   logic [VEC_W-1:0] mem [DEPTH];
   logic [AW-1:0]    last_q;
   logic             loop_q;
   logic             restart, apply;
   logic [AW-1:0]    idx_nxt;

   // NOTE: every output of this block gets a default first so no path leaves a
   // signal unassigned, which would otherwise infer a latch.
   always_comb begin
      state_nxt = state_q;
      restart   = 1'b0;
      apply     = 1'b0;
      idx_nxt   = Vec_idx + AW'(1);
      if (Stop) begin
         state_nxt = IDLE;
      end else begin
         case (state_q)
            IDLE, DONE: begin
               if (Start) begin
                  restart   = 1'b1;
                  apply     = 1'b1;
                  idx_nxt   = '0;
                  state_nxt = (Mode == 2'b10) ? STEP_WAIT : RUN;
               end
            end
            RUN: begin
               if (Vec_idx < last_q) begin
                  apply = 1'b1;
               end else if (loop_q) begin
                  apply   = 1'b1;
                  idx_nxt = '0;
               end else begin
                  state_nxt = DONE;
               end
            end
            STEP_WAIT: begin
               if (Step) begin
                  if (Vec_idx < last_q) apply = 1'b1;
                  else                  state_nxt = DONE;
               end
            end
            default: state_nxt = IDLE;
         endcase
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge Clock or negedge Reset) begin
      if (!Reset) begin
         state_q       <= IDLE;
         Vec_out       <= '0;
         Vec_idx       <= '0;
         Applied_count <= '0;
         last_q        <= '0;
         loop_q        <= 1'b0;
      end else begin
         state_q <= state_nxt;
         if (restart) begin
            last_q <= Last_idx;
            loop_q <= (Mode == 2'b01);
         end
         if (apply) begin
            Vec_idx <= idx_nxt;
            Vec_out <= mem[idx_nxt];
            if (restart)                        Applied_count <= 16'd1;
            else if (Applied_count != 16'hFFFF) Applied_count <= Applied_count + 16'd1;
         end
      end
   end

   // NOTE: the vector table deliberately has no reset; its contents must
   // survive Reset, and leaving it out keeps it a plain register file.
   always_ff @(posedge Clock) begin
      if (Load_en && !Busy) mem[Load_addr] <= Load_data;
   end

   assign Busy      = (state_q == RUN) || (state_q == STEP_WAIT);
   assign Vec_valid = Busy;
   assign Done      = (state_q == DONE);

endmodule

// File: tb/tb_vector_sequencer.sv
// Scoreboard bench for vector_sequencer: expected (index, vector) pairs are
// queued as stimulus is driven and popped as the DUT applies each new vector.
module tb_vector_sequencer;
   localparam int VEC_W = 42;
   localparam int DEPTH = 16;
   localparam int AW    = 4;

   logic             Clock = 1'b0;
   logic             Reset = 1'b1;
   logic             Load_en = 1'b0;
   logic [AW-1:0]    Load_addr = '0;
   logic [VEC_W-1:0] Load_data = '0;
   logic             Start = 1'b0;
   logic             Stop = 1'b0;
   logic             Step = 1'b0;
   logic [1:0]       Mode = 2'b00;
   logic [AW-1:0]    Last_idx = '0;
   logic [VEC_W-1:0] Vec_out;
   logic             Vec_valid;
   logic [AW-1:0]    Vec_idx;
   logic             Busy;
   logic             Done;
   logic [15:0]      Applied_count;

   vector_sequencer #(.VEC_W(VEC_W), .DEPTH(DEPTH), .AW(AW)) dut (
      .Clock(Clock), .Reset(Reset), .Load_en(Load_en), .Load_addr(Load_addr),
      .Load_data(Load_data), .Start(Start), .Stop(Stop), .Step(Step),
      .Mode(Mode), .Last_idx(Last_idx), .Vec_out(Vec_out), .Vec_valid(Vec_valid),
      .Vec_idx(Vec_idx), .Busy(Busy), .Done(Done), .Applied_count(Applied_count)
   );

   always #5 Clock = ~Clock;

   int          checks = 0;
   int          errors = 0;
   logic [63:0] sb_q[$];
   bit          mon_en = 1'b1;
   logic        prev_valid = 1'b0;
   logic [15:0] prev_count = '0;

   task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   function automatic logic [63:0] ent(input int idx, input longint data);
      logic [AW-1:0]    i;
      logic [VEC_W-1:0] d;
      i = AW'(idx);
      d = VEC_W'(data);
      return 64'({i, d});
   endfunction

   task automatic tick(input int n = 1);
      repeat (n) @(posedge Clock);
      #1;
   endtask

   task automatic load(input int addr, input longint data);
      Load_en   = 1'b1;
      Load_addr = AW'(addr);
      Load_data = VEC_W'(data);
      tick();
      Load_en   = 1'b0;
   endtask

   task automatic pulse_start(input logic [1:0] m, input int last);
      Mode     = m;
      Last_idx = AW'(last);
      Start    = 1'b1;
      tick();
      Start    = 1'b0;
   endtask

   task automatic wait_done();
      int n = 0;
      while (!Done && n < 200) begin
         tick();
         n++;
      end
      check("done_reached", 64'(Done), 64'd1);
   endtask

   // A new vector is recognised by Vec_valid rising or the count moving.
   always @(negedge Clock) begin
      if (mon_en && Vec_valid && (!prev_valid || Applied_count != prev_count)) begin
         if (sb_q.size() == 0) check("sb_unexpected", 64'(sb_q.size()), 64'd1);
         else                  check("sb_vec", 64'({Vec_idx, Vec_out}), sb_q.pop_front());
      end
      prev_valid = Vec_valid;
      prev_count = Applied_count;
   end

   initial begin
      #1 Reset = 1'b0;
      #1;
      check("rst_vec_out", 64'(Vec_out), 64'd0);
      check("rst_flags", 64'({Vec_valid, Busy, Done}), 64'd0);
      check("rst_idx", 64'(Vec_idx), 64'd0);
      check("rst_count", 64'(Applied_count), 64'd0);
      tick(2);
      Reset = 1'b1;
      tick();

      for (int i = 0; i < 4; i++) load(i, i + 1);

      // Run-once over slots 0..3
      for (int i = 0; i < 4; i++) sb_q.push_back(ent(i, i + 1));
      pulse_start(2'b00, 3);
      check("run_busy", 64'(Busy), 64'd1);
      wait_done();
      check("run_done_valid", 64'(Vec_valid), 64'd0);
      check("run_done_count", 64'(Applied_count), 64'd4);
      check("run_done_hold", 64'({Vec_idx, Vec_out}), ent(3, 4));
      tick(3);
      check("done_sticky", 64'({Done, Busy}), 64'b10);
      check("sb_drain_run", 64'(sb_q.size()), 64'd0);

      // Loop mode from DONE, stop after six vectors
      for (int i = 0; i < 6; i++) sb_q.push_back(ent(i % 4, (i % 4) + 1));
      pulse_start(2'b01, 3);
      tick(5);
      Stop = 1'b1;
      tick();
      Stop = 1'b0;
      check("loop_stop_flags", 64'({Vec_valid, Busy, Done}), 64'd0);
      check("loop_stop_count", 64'(Applied_count), 64'd6);
      check("loop_stop_hold", 64'(Vec_out), 64'd2);
      tick(3);
      check("loop_count_frozen", 64'(Applied_count), 64'd6);
      check("sb_drain_loop", 64'(sb_q.size()), 64'd0);

      // Single-step mode, pulsed Step
      sb_q.push_back(ent(0, 1));
      pulse_start(2'b10, 2);
      tick(5);
      check("step_hold", 64'({Vec_valid, Busy, Vec_out}), {2'b11, 42'd1});
      for (int i = 1; i <= 2; i++) sb_q.push_back(ent(i, i + 1));
      for (int i = 0; i < 3; i++) begin
         Step = 1'b1;
         tick();
         Step = 1'b0;
         tick();
      end
      check("step_done", 64'({Done, Vec_valid}), 64'b10);
      check("step_count", 64'(Applied_count), 64'd3);

      // Single-step with Step held high advances once per cycle
      for (int i = 0; i < 3; i++) sb_q.push_back(ent(i, i + 1));
      pulse_start(2'b10, 2);
      Step = 1'b1;
      tick(2);
      check("step_held_idx", 64'(Vec_idx), 64'd2);
      tick();
      Step = 1'b0;
      check("step_held_done", 64'(Done), 64'd1);
      check("sb_drain_step", 64'(sb_q.size()), 64'd0);

      // Async reset mid-run, then replay with table intact
      for (int i = 0; i < 3; i++) sb_q.push_back(ent(i, i + 1));
      pulse_start(2'b00, 3);
      tick(2);
      check("pre_rst_idx", 64'(Vec_idx), 64'd2);
      @(negedge Clock);
      #1 Reset = 1'b0;
      #1;
      check("async_rst_out", 64'({Vec_out, Vec_idx}), 64'd0);
      check("async_rst_flags", 64'({Vec_valid, Busy, Done, Applied_count}), 64'd0);
      tick(2);
      Reset = 1'b1;
      tick(2);
      check("post_rst_idle", 64'({Busy, Done}), 64'd0);
      for (int i = 0; i < 4; i++) sb_q.push_back(ent(i, i + 1));
      pulse_start(2'b00, 3);
      wait_done();
      check("sb_drain_rst", 64'(sb_q.size()), 64'd0);

      // Stop beats Start; load while busy is dropped
      Stop = 1'b1;
      pulse_start(2'b00, 3);
      Stop = 1'b0;
      check("start_stop_idle", 64'({Busy, Done, Vec_valid}), 64'd0);
      for (int i = 0; i < 4; i++) sb_q.push_back(ent(i, i + 1));
      pulse_start(2'b00, 3);
      load(1, 'h99);
      wait_done();
      for (int i = 0; i < 4; i++) sb_q.push_back(ent(i, i + 1));
      pulse_start(2'b00, 3);
      wait_done();
      check("sb_drain_busy_load", 64'(sb_q.size()), 64'd0);

      // Load on the Start edge is visible on the next edge
      sb_q.push_back(ent(0, 1));
      sb_q.push_back(ent(1, 'h55));
      Load_en   = 1'b1;
      Load_addr = AW'(1);
      Load_data = VEC_W'('h55);
      pulse_start(2'b00, 1);
      Load_en   = 1'b0;
      wait_done();
      check("sb_drain_load_start", 64'(sb_q.size()), 64'd0);

      // Loop on a single slot until the count saturates
      mon_en = 1'b0;
      pulse_start(2'b01, 0);
      tick(70000);
      check("sat_count", 64'(Applied_count), 64'hFFFF);
      check("sat_vec", 64'({Vec_valid, Vec_idx, Vec_out}), {1'b1, 4'd0, 42'd1});
      Stop = 1'b1;
      tick();
      Stop = 1'b0;
      check("sat_stop", 64'({Busy, Applied_count}), 64'hFFFF);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
